// File: rtl/classifier_arbiter.sv
// classifier_arbiter
// Round-robin arbiter that time-shares one protocol classifier among N_PORTS
// parse lanes. It grants one lane, drives the classifier, and returns a 2-bit
// class to the granted lane. It then waits for the classifier to clear
// proto_valid before granting again.
// Optional feature: define CLS_ARB_TIMEOUT_EN to force a class-0 response
// after TIMEOUT_CYCLES cycles in BUSY without proto_valid.
module classifier_arbiter #(
    parameter int N_PORTS        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_PORTS-1:0]    req_valid,
    input  logic [N_PORTS*16-1:0] req_ethertype,
    output logic [N_PORTS-1:0]    req_ready,
    output logic                  cls_vlan_valid,
    output logic [15:0]           cls_ethertype,
    input  logic                  cls_is_ipv4,
    input  logic                  cls_is_ipv6,
    input  logic                  cls_is_arp,
    input  logic                  cls_is_unknown,
    input  logic                  cls_proto_valid,
    output logic [N_PORTS-1:0]    resp_valid,
    output logic [1:0]            resp_class,
    output logic                  resp_timeout,
    output logic                  busy
);
    localparam int                IDX_W     = $clog2(N_PORTS);
    localparam logic [IDX_W:0]    N_W       = (IDX_W+1)'(N_PORTS);
    localparam logic [IDX_W-1:0]  LAST_LANE = IDX_W'(N_PORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [IDX_W-1:0]   gnt_reg;
    logic [15:0]        et_reg;
    logic [N_PORTS-1:0] resp_valid_reg;
    logic [1:0]         resp_class_reg;
    logic               vlan_valid_reg;
    logic               busy_reg;

    logic [15:0]        lane_et  [N_PORTS];
    logic [IDX_W-1:0]   scan_idx [N_PORTS];
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [1:0]         flag_class;
    logic [N_PORTS-1:0] gnt_onehot;

    genvar gi;
    generate
        if (N_PORTS < 2 || N_PORTS > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
            $error("classifier_arbiter: parameter out of range");
        end

        // scan_idx[k] is the lane examined k-th, starting just above last_grant.
        // The sum never reaches 2*N_PORTS, so one conditional subtraction
        // wraps it.
        for (gi = 0; gi < N_PORTS; gi++) begin : g_lane
            logic [IDX_W:0]   sum;
            logic [IDX_W-1:0] wrapped;
            assign lane_et[gi]  = req_ethertype[16*gi +: 16];
            assign sum          = {1'b0, last_grant_reg} + (IDX_W+1)'(gi + 1);
            assign wrapped      = sum[IDX_W-1:0] - N_W[IDX_W-1:0];
            assign scan_idx[gi] = (sum >= N_W) ? wrapped : sum[IDX_W-1:0];
        end
    endgenerate

    assign gnt_onehot = {{(N_PORTS-1){1'b0}}, 1'b1} << gnt_reg;

`ifdef CLS_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_reg;
    logic       resp_timeout_reg;
    logic       tmo_hit;
    assign tmo_hit      = (tmo_cnt_reg == TMO_LAST);
    assign resp_timeout = resp_timeout_reg;
`else
    assign resp_timeout = 1'b0;
`endif

    // Round-robin pick: the first requesting lane in scan order.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!pick_found && req_valid[scan_idx[k]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[k];
            end
        end
    end

    // Grant pulse, only in IDLE. It is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_reg == S_IDLE && pick_found) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // Flag priority: ipv4 > ipv6 > arp; unknown or no flag gives class 0.
    always_comb begin
        flag_class = 2'd0;
        if (cls_is_ipv4) begin
            flag_class = 2'd1;
        end else if (cls_is_ipv6) begin
            flag_class = 2'd2;
        end else if (cls_is_arp) begin
            flag_class = 2'd3;
        end else if (cls_is_unknown) begin
            flag_class = 2'd0;
        end
    end

    // Sequencer FSM: IDLE -> BUSY -> RESP -> DRAIN -> IDLE. Its outputs are registered together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            last_grant_reg   <= LAST_LANE;
            gnt_reg          <= '0;
            et_reg           <= '0;
            resp_valid_reg   <= '0;
            resp_class_reg   <= 2'd0;
            vlan_valid_reg   <= 1'b0;
            busy_reg         <= 1'b0;
`ifdef CLS_ARB_TIMEOUT_EN
            tmo_cnt_reg      <= '0;
            resp_timeout_reg <= 1'b0;
`endif
        end else begin
            resp_valid_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (pick_found) begin
                        et_reg         <= lane_et[pick_idx];
                        gnt_reg        <= pick_idx;
                        last_grant_reg <= pick_idx;
                        state_reg      <= S_BUSY;
                        vlan_valid_reg <= 1'b1;
                        busy_reg       <= 1'b1;
`ifdef CLS_ARB_TIMEOUT_EN
                        tmo_cnt_reg    <= '0;
`endif
                    end
                end
                S_BUSY: begin
`ifdef CLS_ARB_TIMEOUT_EN
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
`endif
                    if (cls_proto_valid) begin
                        state_reg        <= S_RESP;
                        vlan_valid_reg   <= 1'b0;
                        resp_valid_reg   <= gnt_onehot;
                        resp_class_reg   <= flag_class;
`ifdef CLS_ARB_TIMEOUT_EN
                        resp_timeout_reg <= 1'b0;
                    end else if (tmo_hit) begin
                        state_reg        <= S_RESP;
                        vlan_valid_reg   <= 1'b0;
                        resp_valid_reg   <= gnt_onehot;
                        resp_class_reg   <= 2'd0;
                        resp_timeout_reg <= 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    // The response pulse ends here. The class is cleared so it only ever appears alongside resp_valid.
                    state_reg      <= S_DRAIN;
                    resp_class_reg <= 2'd0;
`ifdef CLS_ARB_TIMEOUT_EN
                    resp_timeout_reg <= 1'b0;
`endif
                end
                S_DRAIN: begin
                    // Hold off the next grant until the classifier has dropped proto_valid.
                    if (!cls_proto_valid) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cls_vlan_valid = vlan_valid_reg;
    assign cls_ethertype  = et_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_class     = resp_class_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_classifier_arbiter.sv
// tb_classifier_arbiter
// Directed bench for classifier_arbiter with an attached classifier model.
// A transaction-level reference model is checked against the DUT on every
// negative clock edge. Hand-computed literal expectations pin down grant
// order, latency and class.
// Define CLS_ARB_TIMEOUT_EN to also build the timeout variant.
module tb_classifier_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*16-1:0] req_ethertype;
    logic [N-1:0]   req_ready;
    logic           cls_vlan_valid;
    logic [15:0]    cls_ethertype;
    logic           cls_is_ipv4, cls_is_ipv6, cls_is_arp, cls_is_unknown;
    logic           cls_proto_valid;
    logic [N-1:0]   resp_valid;
    logic [1:0]     resp_class;
    logic           resp_timeout;
    logic           busy;

    always #5 clk = ~clk;

    classifier_arbiter #(.N_PORTS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ethertype  (req_ethertype),
        .req_ready      (req_ready),
        .cls_vlan_valid (cls_vlan_valid),
        .cls_ethertype  (cls_ethertype),
        .cls_is_ipv4    (cls_is_ipv4),
        .cls_is_ipv6    (cls_is_ipv6),
        .cls_is_arp     (cls_is_arp),
        .cls_is_unknown (cls_is_unknown),
        .cls_proto_valid(cls_proto_valid),
        .resp_valid     (resp_valid),
        .resp_class     (resp_class),
        .resp_timeout   (resp_timeout),
        .busy           (busy)
    );

    // ---------------- classifier model ----------------
    logic [3:0] flags;       // {ipv4, ipv6, arp, unknown}
    logic       stuck      = 1'b0;
    int         extra_hold = 0;
    logic       force_en   = 1'b0;
    logic [3:0] force_flags = 4'b0000;
    int         hold_cnt;

    function automatic logic [3:0] decode_et(input logic [15:0] et);
        case (et)
            16'h0800: return 4'b1000;
            16'h86DD: return 4'b0100;
            16'h0806: return 4'b0010;
            default:  return 4'b0001;
        endcase
    endfunction

    assign {cls_is_ipv4, cls_is_ipv6, cls_is_arp, cls_is_unknown} = flags;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_proto_valid <= 1'b0;
            flags           <= 4'b0000;
            hold_cnt        <= 0;
        end else if (stuck) begin
            cls_proto_valid <= 1'b0;
        end else if (cls_vlan_valid) begin
            cls_proto_valid <= 1'b1;
            flags           <= force_en ? force_flags : decode_et(cls_ethertype);
            hold_cnt        <= 0;
        end else if (cls_proto_valid && hold_cnt < extra_hold) begin
            hold_cnt <= hold_cnt + 1;
        end else begin
            cls_proto_valid <= 1'b0;
            hold_cnt        <= 0;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int unsigned cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Event logs of what the DUT actually did (used for literal expectations).
    int g_lane[$];
    int g_cyc[$];
    int r_lane[$];
    int r_class[$];
    int r_to[$];
    int r_cyc[$];
    int idle_cyc = -1;
    logic prev_busy = 1'b0;

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int lane_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int prio_class(input logic v4, input logic v6, input logic arp);
        if (v4) return 1;
        if (v6) return 2;
        if (arp) return 3;
        return 0;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    // Phase: 0 = free, 1 = waiting for classifier, 2 = responding, 3 = waiting for classifier to clear
    int          m_phase = 0;
    int          m_last  = N - 1;
    int          m_lane  = 0;
    int          m_wait  = 0;
    int          m_class = 0;
    logic        m_to    = 1'b0;
    logic [15:0] m_et    = 16'h0000;
    int          p;
    logic [N-1:0] e_ready, e_resp;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs",
                  {req_ready, resp_valid, resp_class, resp_timeout, busy, cls_vlan_valid, cls_ethertype}, 64'd0);
            m_phase = 0; m_last = N - 1; m_et = 16'h0000; m_to = 1'b0;
            prev_busy = 1'b0;
        end else begin
            e_ready = '0;
            e_resp  = '0;
            p       = -1;
            if (m_phase == 0) begin
                p = rr_pick(m_last, req_valid);
                if (p >= 0) e_ready = onehot(p);
            end
            if (m_phase == 2) e_resp = onehot(m_lane);
            check("req_ready", req_ready, e_ready);
            check("resp_valid", resp_valid, e_resp);
            if (m_phase == 2) check("resp_class", resp_class, m_class[1:0]);
            check("resp_timeout", resp_timeout, (m_phase == 2) ? m_to : 1'b0);
            check("busy_vlan_et", {busy, cls_vlan_valid, cls_ethertype},
                  {m_phase != 0, m_phase == 1, m_et});

            if (req_ready != '0) begin g_lane.push_back(lane_of(req_ready)); g_cyc.push_back(cyc); end
            if (resp_valid != '0) begin
                r_lane.push_back(lane_of(resp_valid));
                r_class.push_back(int'(resp_class));
                r_to.push_back(int'(resp_timeout));
                r_cyc.push_back(cyc);
            end
            if (prev_busy && !busy) idle_cyc = cyc;
            prev_busy = busy;

            case (m_phase)
                0: if (p >= 0) begin
                       m_phase = 1; m_last = p; m_lane = p; m_wait = 0;
                       m_et = req_ethertype[p*16 +: 16];
                   end
                1: begin
                       m_wait++;
                       if (cls_proto_valid) begin
                           m_class = prio_class(cls_is_ipv4, cls_is_ipv6, cls_is_arp);
                           m_to = 1'b0; m_phase = 2;
                       end
`ifdef CLS_ARB_TIMEOUT_EN
                       else if (m_wait == TMO) begin
                           m_class = 0; m_to = 1'b1; m_phase = 2;
                       end
`endif
                   end
                2: m_phase = 3;
                default: if (!cls_proto_valid) m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        g_lane.delete(); g_cyc.delete();
        r_lane.delete(); r_class.delete(); r_to.delete(); r_cyc.delete();
        idle_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick(3);
        rst_n = 1'b1;
        clear_logs();
        tick(1);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k;
        k = 0;
        while (g_lane.size() < n && k < budget) begin tick(1); k++; end
        check("grant_within_budget", 64'(g_lane.size() >= n), 64'd1);
    endtask

    task automatic wait_resps(input int n, input int budget);
        int k;
        k = 0;
        while (r_lane.size() < n && k < budget) begin tick(1); k++; end
        check("resp_within_budget", 64'(r_lane.size() >= n), 64'd1);
    endtask

    // One complete transaction on a single lane.
    task automatic do_txn(input int lane, input logic [15:0] et);
        int g0, r0;
        g0 = g_lane.size();
        r0 = r_lane.size();
        req_ethertype[lane*16 +: 16] = et;
        req_valid[lane] = 1'b1;
        wait_grants(g0 + 1, 20);
        req_valid[lane] = 1'b0;
        wait_resps(r0 + 1, 40);
        tick(8);
    endtask

    logic [3:0] flag_vec [4];
    int         flag_exp [4];

    initial begin
        req_valid     = '0;
        req_ethertype = '0;
        #1;
        do_reset();

        // 1) Lane 1 alone, IPv4.
        do_txn(1, 16'h0800);
        check("t1_grant_lane", g_lane.size() > 0 ? g_lane[0] : -1, 1);
        check("t1_resp_lane", r_lane.size() > 0 ? r_lane[0] : -1, 1);
        check("t1_resp_class", r_class.size() > 0 ? r_class[0] : -1, 1);
        check("t1_latency", (r_cyc.size() > 0 && g_cyc.size() > 0) ? r_cyc[0] - g_cyc[0] : -1, 3);
        check("t1_idle_at_5", g_cyc.size() > 0 ? idle_cyc - int'(g_cyc[0]) : -1, 5);
        $display("txn t1: lane %0d class %0d", r_lane.size() > 0 ? r_lane[0] : -1, r_class.size() > 0 ? r_class[0] : -1);

        // 2) All four lanes requesting continuously.
        do_reset();
        req_ethertype = {16'h1234, 16'h0800, 16'h0806, 16'h86DD};
        req_valid = 4'b1111;
        wait_grants(5, 60);
        req_valid = '0;
        wait_resps(5, 20);
        tick(6);
        for (int i = 0; i < 5; i++) begin
            int exp_lane, exp_cls;
            exp_lane = i % 4;
            exp_cls  = (exp_lane == 0) ? 2 : (exp_lane == 1) ? 3 : (exp_lane == 2) ? 1 : 0;
            check("t2_grant_order", i < g_lane.size() ? g_lane[i] : -1, exp_lane);
            check("t2_class", i < r_class.size() ? r_class[i] : -1, exp_cls);
            if (i > 0) check("t2_spacing", i < g_cyc.size() ? g_cyc[i] - g_cyc[i-1] : -1, 5);
            $display("txn t2[%0d]: lane %0d class %0d", i, i < r_lane.size() ? r_lane[i] : -1,
                     i < r_class.size() ? r_class[i] : -1);
        end

        // 3) Lane 2 pulses req_valid for one cycle while lane 0 is being served.
        do_reset();
        req_ethertype[0 +: 16] = 16'h0800;
        req_valid = 4'b0001;
        wait_grants(1, 20);
        req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        tick(14);
        check("t3_single_grant", g_lane.size(), 1);
        check("t3_single_resp", r_lane.size(), 1);
        check("t3_resp_lane", r_lane.size() > 0 ? r_lane[0] : -1, 0);
        $display("txn t3: grants %0d responses %0d", g_lane.size(), r_lane.size());

        // 4) Reset asserted while BUSY serves lane 3.
        do_reset();
        req_ethertype[48 +: 16] = 16'h86DD;
        req_valid = 4'b1000;
        wait_grants(1, 20);
        req_valid = 4'b0101;
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_reset",
              {req_ready, resp_valid, resp_class, resp_timeout, busy, cls_vlan_valid, cls_ethertype}, 64'd0);
        clear_logs();
        tick(2);
        rst_n = 1'b1;
        wait_grants(1, 20);
        req_valid = '0;
        wait_resps(1, 20);
        tick(8);
        check("t4_first_grant_lane0", g_lane.size() > 0 ? g_lane[0] : -1, 0);
        check("t4_no_stale_resp", r_lane.size(), 1);
        check("t4_resp_lane", r_lane.size() > 0 ? r_lane[0] : -1, 0);
        $display("txn t4: post-reset grant lane %0d", g_lane.size() > 0 ? g_lane[0] : -1);

        // 5) Classifier never answers.
        do_reset();
        stuck = 1'b1;
        req_ethertype[16 +: 16] = 16'h0800;
        req_valid = 4'b0010;
        wait_grants(1, 20);
        req_valid = '0;
`ifdef CLS_ARB_TIMEOUT_EN
        wait_resps(1, 40);
        check("t5_timeout_class", r_class.size() > 0 ? r_class[0] : -1, 0);
        check("t5_timeout_flag", r_to.size() > 0 ? r_to[0] : -1, 1);
        check("t5_timeout_latency", (r_cyc.size() > 0 && g_cyc.size() > 0) ? r_cyc[0] - g_cyc[0] : -1, TMO + 1);
        tick(6);
`else
        tick(30);
        check("t5_no_resp", r_lane.size(), 0);
        check("t5_still_busy", busy, 1'b1);
`endif
        $display("txn t5: responses %0d busy %0b", r_lane.size(), busy);
        stuck = 1'b0;

        // 6) Classifier holds proto_valid 3 extra cycles.
        do_reset();
        extra_hold = 3;
        req_ethertype[0 +: 16]  = 16'h0800;
        req_ethertype[16 +: 16] = 16'h0806;
        req_valid = 4'b0011;
        wait_grants(2, 40);
        req_valid = '0;
        wait_resps(2, 20);
        tick(10);
        check("t6_grant_gap", g_cyc.size() > 1 ? g_cyc[1] - g_cyc[0] : -1, 8);
        check("t6_class0", r_class.size() > 0 ? r_class[0] : -1, 1);
        check("t6_class1", r_class.size() > 1 ? r_class[1] : -1, 3);
        $display("txn t6: grant gap %0d", g_cyc.size() > 1 ? g_cyc[1] - g_cyc[0] : -1);
        extra_hold = 0;

        // 7) Flag priority with several flags set at once.
        do_reset();
        flag_vec[0] = 4'b1110; flag_exp[0] = 1;
        flag_vec[1] = 4'b0110; flag_exp[1] = 2;
        flag_vec[2] = 4'b0011; flag_exp[2] = 3;
        flag_vec[3] = 4'b0000; flag_exp[3] = 0;
        force_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            force_flags = flag_vec[i];
            do_txn(2, 16'h1234);
            check("t7_flag_priority", r_class.size() > i ? r_class[i] : -1, flag_exp[i]);
            $display("txn t7[%0d]: flags %b class %0d", i, flag_vec[i], r_class.size() > i ? r_class[i] : -1);
        end
        force_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
